sprite_fetch: RTL and testbench

Read-side engine for the 32×32, 4-bit sprite BRAM (256 × 16-bit words, 4 pixels per word, 8 words per sprite line). During horizontal blanking it fetches the current scanline's 8 words into an internal line buffer. During the visible portion it emits one 4-bit colour index per pixel, with a transparency flag, to the video compositor. It sits between the video timing generator and the sprite memory read port.

---
 rtl/xosera_pkg.sv | 28 ++
 rtl/sprite_fetch.sv | 122 ++++++++++++
 tb/tb_sprite_fetch.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xosera_pkg.sv
// Shared Xosera constants and types; this slice carries the sprite fetch geometry,
// its state type and the pixel nibble selector.
package xosera_pkg;

    localparam int SPRITE_W              = 32;
    localparam int SPRITE_H              = 32;
    localparam int SPRITE_WORDS_PER_LINE = 8;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        READY
    } sprite_fetch_state_t;

    // Leftmost pixel of a word lives in the top nibble.
    function automatic logic [3:0] sprite_nibble(input logic [15:0] word, input logic [1:0] pos);
        logic [3:0] nib;
        case (pos)
            2'd0:    nib = word[15:12];
            2'd1:    nib = word[11:8];
            2'd2:    nib = word[7:4];
            default: nib = word[3:0];
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/sprite_fetch.sv
// Sprite line fetch engine: loads one 8-word sprite line during hblank, then
// serves registered 4-bit colour indices with a transparency flag while visible.
module sprite_fetch
    import xosera_pkg::*;
#(
    parameter int AWIDTH = 8
) (
    input  logic              clk,
    input  logic              reset_n_i,
    input  logic              sprite_en_i,
    input  logic [10:0]       sprite_x_i,
    input  logic [10:0]       sprite_y_i,
    input  logic              line_start_i,
    input  logic [10:0]       v_count_i,
    input  logic [10:0]       h_count_i,
    output logic              rd_en_o,
    output logic [AWIDTH-1:0] rd_address_o,
    input  logic [15:0]       rd_data_i,
    output logic [3:0]        pixel_o,
    output logic              pixel_valid_o,
    output logic              busy_o
);

    sprite_fetch_state_t state, state_next;
    logic [2:0]  word_cnt, word_cnt_next;
    logic [4:0]  row_q, row_next;
    logic        buf_valid, buf_valid_next;
    logic        rd_pend;
    logic [2:0]  pend_slot;
    logic [15:0] line_buf [SPRITE_WORDS_PER_LINE];
    logic [10:0] row_calc;
    logic [10:0] col_calc;
    logic        start_ok;
    logic [7:0]  fetch_addr;
    logic [3:0]  nibble;
    logic        opaque;

    // Subtractions are 11-bit so sprites wrap at 2048 on both axes.
    assign row_calc = v_count_i - sprite_y_i;
    assign col_calc = h_count_i - sprite_x_i;
    assign start_ok = sprite_en_i && (row_calc < 11'(SPRITE_H));

    assign nibble = sprite_nibble(line_buf[col_calc[4:2]], col_calc[1:0]);
    assign opaque = (state == READY) && buf_valid && sprite_en_i &&
                    (col_calc < 11'(SPRITE_W)) && (nibble != 4'h0);

    assign rd_address_o = AWIDTH'(fetch_addr);

    always_comb begin
        state_next     = state;
        word_cnt_next  = word_cnt;
        row_next       = row_q;
        buf_valid_next = buf_valid;
        rd_en_o        = 1'b0;
        busy_o         = 1'b0;
        fetch_addr     = 8'h00;

        case (state)
            IDLE: begin
            end
            FETCH: begin
                rd_en_o       = 1'b1;
                busy_o        = 1'b1;
                fetch_addr    = {row_q, word_cnt};
                word_cnt_next = word_cnt + 3'd1;
                if (word_cnt == 3'(SPRITE_WORDS_PER_LINE - 1)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy_o         = 1'b1;
                state_next     = READY;
                buf_valid_next = 1'b1;
            end
            READY: begin
            end
            default: state_next = IDLE;
        endcase

        // A new line always wins, including over a fetch still in flight.
        if (line_start_i) begin
            buf_valid_next = 1'b0;
            word_cnt_next  = 3'd0;
            if (start_ok) begin
                state_next = FETCH;
                row_next   = row_calc[4:0];
            end else begin
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state         <= IDLE;
            word_cnt      <= 3'd0;
            row_q         <= 5'd0;
            buf_valid     <= 1'b0;
            rd_pend       <= 1'b0;
            pend_slot     <= 3'd0;
            pixel_o       <= 4'h0;
            pixel_valid_o <= 1'b0;
            for (int i = 0; i < SPRITE_WORDS_PER_LINE; i++) begin
                line_buf[i] <= 16'h0000;
            end
        end else begin
            state     <= state_next;
            word_cnt  <= word_cnt_next;
            row_q     <= row_next;
            buf_valid <= buf_valid_next;
            // Data returns one cycle after the read; drop the return of an aborted read.
            rd_pend   <= rd_en_o && !line_start_i;
            pend_slot <= word_cnt;
            if (rd_pend) begin
                line_buf[pend_slot] <= rd_data_i;
            end
            pixel_valid_o <= opaque;
            pixel_o       <= opaque ? nibble : 4'h0;
        end
    end

endmodule

// File: tb/tb_sprite_fetch.sv
// Self-checking bench for sprite_fetch: directed scenarios with literal expectations
// plus randomized lines compared every cycle against a timing-level reference model.
module tb_sprite_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sprite_en;
    logic [10:0] sprite_x;
    logic [10:0] sprite_y;
    logic        line_start;
    logic [10:0] v_count;
    logic [10:0] h_count;
    logic        rd_en;
    logic [7:0]  rd_address;
    logic [15:0] rd_data = 16'h0000;
    logic [3:0]  pixel;
    logic        pixel_valid;
    logic        busy;

    logic [15:0] mem [256];

    int  n_checks   = 0;
    int  n_pass     = 0;
    bit  compare_on = 0;

    // Reference model state: the last accepted fetch and a snapshot of its line.
    int          cyc       = 0;
    bit          active    = 0;
    int          start_cyc = 0;
    int          srow      = 0;
    logic [15:0] model_line [8];
    bit          exp_pv    = 0;
    int          exp_pix   = 0;

    always #5 clk = ~clk;

    sprite_fetch #(.AWIDTH(8)) dut (
        .clk          (clk),
        .reset_n_i    (reset_n),
        .sprite_en_i  (sprite_en),
        .sprite_x_i   (sprite_x),
        .sprite_y_i   (sprite_y),
        .line_start_i (line_start),
        .v_count_i    (v_count),
        .h_count_i    (h_count),
        .rd_en_o      (rd_en),
        .rd_address_o (rd_address),
        .rd_data_i    (rd_data),
        .pixel_o      (pixel),
        .pixel_valid_o(pixel_valid),
        .busy_o       (busy)
    );

    // Sprite memory: registered read port on the same clock.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_address];
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    endtask

    // Holds the given inputs for one cycle; returns 1 time unit after the next edge.
    task automatic applyStimulus(input logic ls, input logic [10:0] h);
        line_start = ls;
        h_count    = h;
        @(posedge clk);
        #1;
        line_start = 1'b0;
    endtask

    always @(posedge clk) begin
        int col, row, nib;
        if (!reset_n) begin
            active  = 0;
            exp_pv  = 0;
            exp_pix = 0;
        end else begin
            col     = (int'(h_count) - int'(sprite_x)) & 2047;
            exp_pv  = 0;
            exp_pix = 0;
            if (active && (cyc - start_cyc) >= 10 && sprite_en && col < 32) begin
                nib = (int'(model_line[col / 4]) >> (4 * (3 - col % 4))) & 15;
                if (nib != 0) begin
                    exp_pv  = 1;
                    exp_pix = nib;
                end
            end
            if (line_start) begin
                row = (int'(v_count) - int'(sprite_y)) & 2047;
                if (sprite_en && row < 32) begin
                    active    = 1;
                    start_cyc = cyc;
                    srow      = row;
                    for (int k = 0; k < 8; k++) model_line[k] = mem[srow * 8 + k];
                end else begin
                    active = 0;
                end
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        int phase, ea;
        bit er, eb;
        if (compare_on) begin
            phase = cyc - start_cyc;
            er    = reset_n && active && phase >= 1 && phase <= 8;
            eb    = reset_n && active && phase >= 1 && phase <= 9;
            ea    = srow * 8 + phase - 1;
            checkOutput("rd_en", int'(rd_en), int'(er));
            if (er) checkOutput("rd_address", int'(rd_address), ea);
            checkOutput("busy", int'(busy), int'(eb));
            checkOutput("pixel_valid", int'(pixel_valid), reset_n ? int'(exp_pv) : 0);
            checkOutput("pixel", int'(pixel), reset_n ? exp_pix : 0);
        end
    end

    initial begin
        int busy_cnt, rd_cnt;
        int tv_valid [4];
        int tv_pix [4];
        tv_valid = '{0, 1, 0, 0};
        tv_pix   = '{0, 15, 0, 0};

        sprite_en  = 1'b0;
        sprite_x   = 11'd0;
        sprite_y   = 11'd0;
        line_start = 1'b0;
        v_count    = 11'd0;
        h_count    = 11'd0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[40] = 16'h1234;
        mem[42] = 16'hA000;
        mem[48] = 16'h5000;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        compare_on = 1;

        // Reset held while line_start pulses
        @(posedge clk);
        #1;
        sprite_en = 1'b1;
        sprite_y  = 11'd100;
        v_count   = 11'd105;
        rd_cnt    = 0;
        applyStimulus(1, 0);
        rd_cnt += int'(rd_en);
        applyStimulus(0, 0);
        applyStimulus(1, 0);
        rd_cnt += int'(rd_en);
        checkOutput("reset_reads", rd_cnt, 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_address", int'(rd_address), 0);
        checkOutput("reset_pixel_valid", int'(pixel_valid), 0);
        reset_n = 1'b1;
        applyStimulus(0, 0);
        checkOutput("idle_after_reset_busy", int'(busy), 0);

        // Basic fetch of row 5
        sprite_x = 11'd200;
        busy_cnt = 0;
        applyStimulus(1, 0);
        for (int k = 0; k < 8; k++) begin
            checkOutput("fetch_rd_en", int'(rd_en), 1);
            checkOutput("fetch_address", int'(rd_address), 40 + k);
            busy_cnt += int'(busy);
            applyStimulus(0, 0);
        end
        checkOutput("drain_rd_en", int'(rd_en), 0);
        busy_cnt += int'(busy);
        applyStimulus(0, 0);
        checkOutput("ready_busy", int'(busy), 0);
        checkOutput("busy_cycles", busy_cnt, 9);

        // Pixels of word 0x1234, then just outside both edges
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 11'(200 + k));
            checkOutput("pix_valid_1234", int'(pixel_valid), 1);
            checkOutput("pix_value_1234", int'(pixel), k + 1);
        end
        applyStimulus(0, 11'd199);
        checkOutput("left_edge_valid", int'(pixel_valid), 0);
        applyStimulus(0, 11'd232);
        checkOutput("right_edge_valid", int'(pixel_valid), 0);

        // Transparency
        mem[40] = 16'h0F00;
        applyStimulus(1, 0);
        repeat (9) applyStimulus(0, 0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 11'(200 + k));
            checkOutput("transp_valid", int'(pixel_valid), tv_valid[k]);
            checkOutput("transp_pixel", int'(pixel), tv_pix[k]);
        end

        // Out-of-range line: no reads, idle
        v_count = 11'd132;
        rd_cnt  = 0;
        applyStimulus(1, 0);
        repeat (12) begin
            rd_cnt += int'(rd_en);
            applyStimulus(0, 11'd201);
        end
        checkOutput("oor_reads", rd_cnt, 0);
        checkOutput("oor_busy", int'(busy), 0);
        checkOutput("oor_pixel_valid", int'(pixel_valid), 0);

        // Horizontal wrap: x=2040, h=0 is column 8
        v_count  = 11'd105;
        sprite_x = 11'd2040;
        applyStimulus(1, 0);
        repeat (9) applyStimulus(0, 0);
        applyStimulus(0, 11'd0);
        checkOutput("wrap_valid", int'(pixel_valid), 1);
        checkOutput("wrap_pixel", int'(pixel), 10);

        // Abort at cycle 4 with row 6
        rd_cnt = 0;
        applyStimulus(1, 0);
        repeat (3) begin
            rd_cnt += int'(rd_en);
            applyStimulus(0, 0);
        end
        rd_cnt += int'(rd_en);
        v_count = 11'd106;
        applyStimulus(1, 0);
        for (int k = 0; k < 8; k++) begin
            checkOutput("abort_address", int'(rd_address), 48 + k);
            rd_cnt += int'(rd_en);
            applyStimulus(0, 0);
        end
        rd_cnt += int'(rd_en);
        applyStimulus(0, 0);
        checkOutput("abort_total_reads", rd_cnt, 12);
        applyStimulus(0, 11'd2040);
        checkOutput("abort_row6_pixel", int'(pixel), 5);

        // Enable drops mid-fetch: fetch completes, output transparent until re-enabled
        rd_cnt = 0;
        applyStimulus(1, 0);
        for (int p = 1; p <= 9; p++) begin
            if (p == 3) sprite_en = 1'b0;
            rd_cnt += int'(rd_en);
            applyStimulus(0, 0);
        end
        checkOutput("en_drop_reads", rd_cnt, 8);
        applyStimulus(0, 11'd2040);
        checkOutput("en_drop_valid", int'(pixel_valid), 0);
        sprite_en = 1'b1;
        applyStimulus(0, 11'd2040);
        checkOutput("en_restore_pixel", int'(pixel), 5);

        // Asynchronous reset in the middle of a fetch
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_rst_rd_en", int'(rd_en), 0);
        checkOutput("async_rst_busy", int'(busy), 0);
        checkOutput("async_rst_pixel_valid", int'(pixel_valid), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        applyStimulus(0, 11'd2040);
        checkOutput("after_rst_valid", int'(pixel_valid), 0);
        checkOutput("after_rst_busy", int'(busy), 0);

        // Randomized lines with aborts, enable toggles and y changes mid-fetch
        for (int l = 0; l < 60; l++) begin
            int d, ab;
            sprite_en = 1'(($urandom % 8) != 0);
            sprite_y  = 11'($urandom);
            sprite_x  = 11'($urandom);
            d         = int'($urandom % 48);
            v_count   = sprite_y + 11'(d);
            ab        = (($urandom % 4) == 0) ? int'(1 + $urandom % 9) : 0;
            applyStimulus(1, 11'($urandom));
            for (int p = 1; p <= 11; p++) begin
                if (p == 3) sprite_y = 11'($urandom);
                if (p == 5 && ($urandom % 4) == 0) sprite_en = ~sprite_en;
                if (p == ab) begin
                    v_count  = v_count + 11'd1;
                    sprite_y = v_count - 11'($urandom % 40);
                end
                applyStimulus(1'(p == ab), 11'($urandom));
            end
            for (int i = 0; i < 44; i++) begin
                if (($urandom % 16) == 0) sprite_en = ~sprite_en;
                applyStimulus(0, sprite_x - 11'd4 + 11'(i));
            end
        end

        compare_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
